traffic_request_conditioner: RTL

//  Upstream front end of the traffic controller "main". Turns raw, asynchronous field

---
 rtl/traffic_request_conditioner_pkg.sv | 19 +
 rtl/traffic_request_conditioner_sync2.sv | 23 ++
 rtl/traffic_request_conditioner.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/traffic_request_conditioner_pkg.sv
// Shared definitions for the traffic request conditioner: FSM state encoding and default timing.
package traffic_request_conditioner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_QUAL   = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_COOL   = 3'd4
    } emg_state_t;

    localparam int DEF_DEB_CYCLES = 3;
    localparam int DEF_EMG_QUAL   = 2;
    localparam int DEF_EMG_HOLD   = 4;
    localparam int DEF_EMG_COOL   = 4;
    localparam int DEF_EMG_MAX    = 20;
    localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/traffic_request_conditioner_sync2.sv
// Two-flop synchroniser for an asynchronous field input, synchronous active-low reset.
module traffic_request_conditioner_sync2
    import traffic_request_conditioner_pkg::*;
(
    input  logic Clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge Clk) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/traffic_request_conditioner.sv
// Conditions loop-detector and transponder inputs into clean C / Emergency requests.
// Optional REQ_STATS_EN adds saturating car_count / emg_count statistics ports.
module traffic_request_conditioner
    import traffic_request_conditioner_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int EMG_QUAL   = DEF_EMG_QUAL,
    parameter int EMG_HOLD   = DEF_EMG_HOLD,
    parameter int EMG_COOL   = DEF_EMG_COOL,
    parameter int EMG_MAX    = DEF_EMG_MAX,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic Clk,
    input  logic reset,
    input  logic car_raw,
    input  logic emerg_raw,
    output logic C,
    output logic Emergency,
    output logic em_fault
`ifdef REQ_STATS_EN
    ,
    output logic [CNT_W-1:0] car_count,
    output logic [CNT_W-1:0] emg_count
`endif
);

    // The sample that causes entry into QUAL/HOLD counts as the first one of that window.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'((EMG_QUAL > 1) ? EMG_QUAL - 2 : 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((EMG_HOLD > 1) ? EMG_HOLD - 2 : 0);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(EMG_COOL - 1);
    localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(EMG_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic             car_s;
    logic             emg_s;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_cnt;
    emg_state_t       state;
    logic             car_flip;
    logic             qual_done;
    logic             timeout;

    traffic_request_conditioner_sync2 u_sync_car (
        .Clk   (Clk),
        .reset (reset),
        .d     (car_raw),
        .q     (car_s)
    );

    traffic_request_conditioner_sync2 u_sync_emg (
        .Clk   (Clk),
        .reset (reset),
        .d     (emerg_raw),
        .q     (emg_s)
    );

    assign car_flip  = (car_s != C) && (deb_cnt >= DEB_LAST);
    assign qual_done = emg_s && (((state == ST_QUAL) && (cnt >= QUAL_LAST)) ||
                                 ((state == ST_IDLE) && (EMG_QUAL == 1)));
    assign timeout   = ((state == ST_ACTIVE) || (state == ST_HOLD)) && (act_cnt >= MAX_LAST);

    always_ff @(posedge Clk) begin
        if (!reset) begin
            C       <= 1'b0;
            deb_cnt <= '0;
        end else if (car_s == C) begin
            deb_cnt <= '0;
        end else if (car_flip) begin
            C       <= ~C;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= sat_inc(deb_cnt);
        end
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            act_cnt   <= '0;
            Emergency <= 1'b0;
            em_fault  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_QUAL: begin
                    if (qual_done) begin
                        state     <= ST_ACTIVE;
                        Emergency <= 1'b1;
                        cnt       <= '0;
                        act_cnt   <= '0;
                    end else if (state == ST_IDLE) begin
                        if (emg_s) begin
                            state <= ST_QUAL;
                            cnt   <= '0;
                        end
                    end else if (!emg_s) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                ST_ACTIVE, ST_HOLD: begin
                    // The timeout wins over any request change on the same edge.
                    if (timeout) begin
                        state     <= ST_COOL;
                        Emergency <= 1'b0;
                        em_fault  <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        act_cnt <= sat_inc(act_cnt);
                        if (state == ST_ACTIVE) begin
                            if (!emg_s) begin
                                cnt <= '0;
                                if (EMG_HOLD > 1) begin
                                    state <= ST_HOLD;
                                end else begin
                                    state     <= ST_COOL;
                                    Emergency <= 1'b0;
                                end
                            end
                        end else if (emg_s) begin
                            state <= ST_ACTIVE;
                            cnt   <= '0;
                        end else if (cnt >= HOLD_LAST) begin
                            state     <= ST_COOL;
                            Emergency <= 1'b0;
                            cnt       <= '0;
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end
                end
                ST_COOL: begin
                    if (cnt >= COOL_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    Emergency <= 1'b0;
                    cnt       <= '0;
                end
            endcase
        end
    end

`ifdef REQ_STATS_EN
    always_ff @(posedge Clk) begin
        if (!reset) begin
            car_count <= '0;
            emg_count <= '0;
        end else begin
            if (car_flip && !C) car_count <= sat_inc(car_count);
            if (qual_done) emg_count <= sat_inc(emg_count);
        end
    end
`endif

endmodule
